// File: rtl/filter_scheduler.sv
// Per-channel DEPTH-sample debouncer scanned one channel per cycle every PRESCALE clocks; sig_out lands one cycle after its scan slot.
// Change events (built only with FILTER_SCHED_EVT_EN) wait in pending until evt_ready; stalls never block filtering.
module filter_scheduler #(
   parameter int CHANNELS = 4,
   parameter int PRESCALE = 8,
   parameter int DEPTH    = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [CHANNELS-1:0]         sig_in,
   output logic [CHANNELS-1:0]         sig_out,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [$clog2(CHANNELS)-1:0] evt_chan,
   output logic                        evt_level,
   output logic                        overrun,
   output logic                        busy
);
   localparam int CW = $clog2(CHANNELS);
   localparam int PW = $clog2(PRESCALE);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       idx_q, idx_d;
   logic [DEPTH-1:0]    hist_q [CHANNELS];
   logic [DEPTH-1:0]    hist_d [CHANNELS];
   logic [CHANNELS-1:0] sig_out_q, sig_out_d;
   logic [DEPTH-1:0]    hist_new;
   logic                tick;
   logic                scan_vld;

   always_comb begin
      tick     = (cnt_q == PW'(PRESCALE-1));
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      scan_vld = (state_q == SCAN);
      state_d  = state_q;
      idx_d    = idx_q;
      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (idx_q == CW'(CHANNELS-1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      endcase

      hist_d    = hist_q;
      sig_out_d = sig_out_q;
      hist_new  = '0;
      if (scan_vld) begin
         // newest sample at bit 0; output moves only on a full run of equal samples
         hist_new      = {hist_q[idx_q][DEPTH-2:0], sig_in[idx_q]};
         hist_d[idx_q] = hist_new;
         if (&hist_new) begin
            sig_out_d[idx_q] = 1'b1;
         end else if (~|hist_new) begin
            sig_out_d[idx_q] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sig_out_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sig_out_q <= sig_out_d;
         hist_q    <= hist_d;
      end
   end

   assign sig_out = sig_out_q;
   assign busy    = (state_q == SCAN);

   // A scan always finishes before the next tick when PRESCALE > CHANNELS.
   assert property (@(posedge clock) disable iff (reset) (state_q == SCAN) |-> !tick);

`ifdef FILTER_SCHED_EVT_EN
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CW-1:0]       rr_q, rr_d;
   logic [CW-1:0]       hold_chan_q, hold_chan_d;
   logic                hold_q, hold_d;
   logic                ovr_q, ovr_d;
   logic [CW-1:0]       sel_chan;
   logic [CW-1:0]       cand;
   logic                any_pend;
   logic                accept;
   logic                change;
   int                  c;

   always_comb begin
      sel_chan = '0;
      cand     = '0;
      c        = 0;
      // descending walk so the lowest offset from rr_q is the one that sticks
      for (int i = CHANNELS-1; i >= 0; i--) begin
         c    = (int'(rr_q) + i) % CHANNELS;
         cand = CW'(c);
         if (pend_q[cand]) begin
            sel_chan = cand;
         end
      end
      // a stalled event keeps its channel even if an earlier one becomes pending
      if (hold_q) begin
         sel_chan = hold_chan_q;
      end

      any_pend = |pend_q;
      accept   = any_pend & evt_ready;
      change   = scan_vld & (sig_out_d[idx_q] != sig_out_q[idx_q]);

      pend_d = pend_q;
      rr_d   = rr_q;
      ovr_d  = ovr_q;
      if (accept) begin
         pend_d[sel_chan] = 1'b0;
         rr_d = (sel_chan == CW'(CHANNELS-1)) ? '0 : sel_chan + 1'b1;
      end
      if (change) begin
         if (pend_q[idx_q] && !(accept && (sel_chan == idx_q))) begin
            ovr_d = 1'b1;
         end
         pend_d[idx_q] = 1'b1;
      end
      hold_d      = any_pend & ~evt_ready;
      hold_chan_d = sel_chan;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q      <= '0;
         rr_q        <= '0;
         hold_q      <= 1'b0;
         hold_chan_q <= '0;
         ovr_q       <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         rr_q        <= rr_d;
         hold_q      <= hold_d;
         hold_chan_q <= hold_chan_d;
         ovr_q       <= ovr_d;
      end
   end

   assign evt_valid = any_pend;
   assign evt_chan  = sel_chan;
   assign evt_level = sig_out_q[sel_chan];
   assign overrun   = ovr_q;
`else
   logic unused_evt_ready;

   assign unused_evt_ready = evt_ready;
   assign evt_valid        = 1'b0;
   assign evt_chan         = '0;
   assign evt_level        = 1'b0;
   assign overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_filter_scheduler.sv
// Directed bench for filter_scheduler: run-length/schedule model compared every cycle, plus hand-computed checkpoints.
module tb_filter_scheduler;
   localparam int C = 4;
   localparam int P = 8;
   localparam int D = 3;
`ifdef FILTER_SCHED_EVT_EN
   localparam int EVT_ON = 1;
`else
   localparam int EVT_ON = 0;
`endif

   logic         clock;
   logic         reset;
   logic [C-1:0] sig_in;
   logic [C-1:0] sig_out;
   logic         evt_valid;
   logic         evt_ready;
   logic [1:0]   evt_chan;
   logic         evt_level;
   logic         overrun;
   logic         busy;

   int n_checks;
   int n_fail;
   int evt_hi_cnt;
   int k_busy;

   filter_scheduler #(.CHANNELS(C), .PRESCALE(P), .DEPTH(D)) dut (
      .clock     (clock),
      .reset     (reset),
      .sig_in    (sig_in),
      .sig_out   (sig_out),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_chan  (evt_chan),
      .evt_level (evt_level),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   bit model_ok;
   int n_edge;
   int run_len [C];
   bit run_val [C];
   bit m_out   [C];
   bit m_pend  [C];
   int m_rr;
   bit m_ovr;
   bit m_held;
   int m_held_chan;

   initial model_ok = 1'b0;

   function automatic bit m_any();
      for (int i = 0; i < C; i++) if (m_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_pick();
      if (m_held) return m_held_chan;
      for (int i = 0; i < C; i++) if (m_pend[(m_rr + i) % C]) return (m_rr + i) % C;
      return 0;
   endfunction

   always @(posedge clock) begin
      bit v, acc, chg, was_pend, nv;
      int ch, c;
      if (reset) begin
         n_edge = 0; m_rr = 0; m_ovr = 0; m_held = 0; m_held_chan = 0;
         for (int i = 0; i < C; i++) begin
            run_len[i] = D; run_val[i] = 0; m_out[i] = 0; m_pend[i] = 0;
         end
         model_ok = 1'b1;
      end else if (model_ok) begin
         n_edge++;
         v = m_any(); ch = m_pick(); acc = v && (evt_ready == 1'b1);
         chg = 0; c = -1; was_pend = 0;
         // channel c is sampled on edge P*(m+1)+1+c after reset
         if ((n_edge - 1) >= P && ((n_edge - 1) % P) < C) begin
            c = (n_edge - 1) % P;
            if (run_val[c] == sig_in[c]) begin
               if (run_len[c] < D) run_len[c]++;
            end else begin
               run_val[c] = sig_in[c]; run_len[c] = 1;
            end
            nv = (run_len[c] >= D) ? run_val[c] : m_out[c];
            chg = (nv != m_out[c]);
            m_out[c] = nv;
            was_pend = m_pend[c];
         end
         if (acc) begin
            m_pend[ch] = 0; m_rr = (ch + 1) % C;
         end
         if (chg) begin
            if (was_pend && !(acc && ch == c)) m_ovr = 1;
            m_pend[c] = 1;
         end
         m_held = v && (evt_ready == 1'b0);
         m_held_chan = ch;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      logic [C-1:0] exp_out;
      bit ev;
      if (model_ok) begin
         for (int i = 0; i < C; i++) exp_out[i] = m_out[i];
         ev = (EVT_ON != 0) && m_any();
         check("sig_out", sig_out, exp_out);
         check("busy", busy, (n_edge >= P) && ((n_edge % P) < C));
         check("evt_valid", evt_valid, ev);
         check("overrun", overrun, (EVT_ON != 0) && m_ovr);
         if (ev) begin
            check("evt_chan", evt_chan, m_pick());
            check("evt_level", evt_level, m_out[m_pick()]);
         end
         if (evt_valid === 1'b1) evt_hi_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_edges(input int k);
      repeat (k) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic apply_reset(input int cyc);
      @(negedge clock);
      reset = 1'b1;
      repeat (cyc) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0; evt_hi_cnt = 0;
      reset = 1'b1; sig_in = '0; evt_ready = 1'b1;

      // ch0 held high from reset, consumer always ready
      apply_reset(2);
      sig_in = 4'b0001; evt_ready = 1'b1; evt_hi_cnt = 0;
      check("t1_reset_busy", busy, 0);
      check("t1_reset_valid", evt_valid, 0);
      wait_edges(24);
      check("t1_pre_rise", sig_out, 4'b0000);
      check("t1_busy_idx0", busy, 1);
      wait_edges(1);
      check("t1_rise", sig_out, 4'b0001);
      check("t1_valid", evt_valid, EVT_ON);
      check("t1_chan", evt_chan, 0);
      check("t1_level", evt_level, EVT_ON);
      wait_edges(1);
      check("t1_accepted", evt_valid, 0);
      wait_edges(10);
      check("t1_one_event", evt_hi_cnt, EVT_ON);

      // ch1 toggling once per tick never settles
      apply_reset(1);
      sig_in = '0; evt_ready = 1'b1; evt_hi_cnt = 0;
      for (int t = 0; t < 10; t++) begin
         sig_in = (t % 2 == 1) ? 4'b0010 : 4'b0000;
         wait_edges(8);
      end
      check("t2_sig_out", sig_out, 4'b0000);
      check("t2_no_evt", evt_hi_cnt, 0);

      // ch0 and ch2 rise in the same scan while stalled
      apply_reset(1);
      sig_in = 4'b0101; evt_ready = 1'b0;
      wait_edges(25);
      check("t3_first_valid", evt_valid, EVT_ON);
      check("t3_first_chan", evt_chan, 0);
      wait_edges(2);
      check("t3_both_out", sig_out, 4'b0101);
      check("t3_hold_chan", evt_chan, 0);
      wait_edges(18);
      check("t3_stall_chan", evt_chan, 0);
      check("t3_stall_level", evt_level, EVT_ON);
      evt_ready = 1'b1;
      wait_edges(1);
      check("t3_second_valid", evt_valid, EVT_ON);
      check("t3_second_chan", evt_chan, (EVT_ON != 0) ? 2 : 0);
      check("t3_second_level", evt_level, EVT_ON);
      wait_edges(1);
      check("t3_drained", evt_valid, 0);

      // ch3 rises then falls with no consumer: overrun
      apply_reset(1);
      sig_in = 4'b1000; evt_ready = 1'b0;
      wait_edges(28);
      check("t4_rise", sig_out, 4'b1000);
      check("t4_chan", evt_chan, (EVT_ON != 0) ? 3 : 0);
      check("t4_no_ovr_yet", overrun, 0);
      sig_in = 4'b0000;
      wait_edges(24);
      check("t4_fall", sig_out, 4'b0000);
      check("t4_overrun", overrun, EVT_ON);
      check("t4_pending", evt_valid, EVT_ON);
      check("t4_level", evt_level, 0);
      evt_ready = 1'b1;
      wait_edges(1);
      check("t4_drained", evt_valid, 0);
      check("t4_ovr_sticky", overrun, EVT_ON);

      // accept and new change on ch0 land on the same edge: set wins, no overrun
      apply_reset(1);
      sig_in = 4'b0001; evt_ready = 1'b0;
      wait_edges(25);
      check("t5_rise_valid", evt_valid, EVT_ON);
      sig_in = 4'b0000;
      wait_edges(23);
      check("t5_still_high", sig_out, 4'b0001);
      evt_ready = 1'b1;
      wait_edges(1);
      check("t5_fall", sig_out, 4'b0000);
      check("t5_set_wins", evt_valid, EVT_ON);
      check("t5_chan", evt_chan, 0);
      check("t5_level", evt_level, 0);
      check("t5_no_overrun", overrun, 0);
      wait_edges(1);
      check("t5_drained", evt_valid, 0);

      // reset pulsed mid-scan at idx 2
      apply_reset(1);
      sig_in = 4'b1111; evt_ready = 1'b0;
      wait_edges(26);
      check("t6_busy_before", busy, 1);
      check("t6_partial_out", sig_out, 4'b0011);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("t6_rst_sig_out", sig_out, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", evt_valid, 0);
      check("t6_rst_overrun", overrun, 0);
      k_busy = -1;
      for (int k = 1; k <= 3 * P; k++) begin
         wait_edges(1);
         if (busy === 1'b1) begin
            k_busy = k;
            break;
         end
      end
      check("t6_busy_delay", k_busy, P);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/filter_scheduler.md
FILTER_SCHEDULER -- requirements
Module: filter_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels, range 2..16.
REQ-002 SHALL have parameter PRESCALE, default 8: clocks per sample tick; must be at least CHANNELS+1.
REQ-003 SHALL have parameter DEPTH, default 3: consecutive equal samples needed to change a filtered output, range 2..8.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sig_in, input, CHANNELS bits: raw per-channel inputs.
REQ-007 SHALL have port sig_out, output, CHANNELS bits: filtered per-channel levels, registered.
REQ-008 SHALL have port evt_valid, output, 1 bit: a change event is presented.
REQ-009 SHALL have port evt_ready, input, 1 bit: consumer accepts the event.
REQ-010 SHALL have port evt_chan, output, clog2(CHANNELS) bits: channel index of the presented event.
REQ-011 SHALL have port evt_level, output, 1 bit: current sig_out level of evt_chan.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, a change occurred while that channel's event was still pending.
REQ-013 SHALL have port busy, output, 1 bit: high while the FSM is in SCAN.

Function
REQ-014 SHALL run a prescaler counting 0..PRESCALE-1 and wrapping; tick is high when count==PRESCALE-1.
REQ-015 SHALL use FSM states IDLE and SCAN: IDLE->SCAN on tick with idx=0; in SCAN, idx increments each cycle; SCAN->IDLE in the cycle after idx==CHANNELS-1 is processed.
REQ-016 SHALL, in the SCAN cycle for channel idx, shift sig_in[idx] into that channel's DEPTH-bit history, newest at bit 0.
REQ-017 SHALL, in that same cycle, evaluate the updated history: all ones sets sig_out[idx]; all zeros clears it; otherwise sig_out[idx] holds. sig_out is visible on the next edge.
REQ-018 SHALL leave channels not being scanned untouched: no history shift and no output change.
REQ-019 SHALL ignore a tick seen in SCAN; the PRESCALE constraint makes this unreachable, and assertions flag it.
REQ-020 SHALL set pending[idx] when sig_out[idx] changes value.
REQ-021 SHALL, if pending[idx] is already set when that change occurs, keep pending set and set overrun.
REQ-022 SHALL assert evt_valid whenever any pending bit is set.
REQ-023 SHALL select evt_chan round-robin: the first pending channel at or after rr_ptr, with wrap-around.
REQ-024 SHALL hold evt_chan and evt_level stable while evt_valid=1 and evt_ready=0, except that evt_level follows sig_out if the channel toggles again.
REQ-025 SHALL, on evt_valid and evt_ready in the same cycle, clear the pending bit of evt_chan and set rr_ptr=evt_chan+1 (wrapping).
REQ-026 SHALL let the set win when a pending bit is set and cleared in the same cycle: the bit stays 1 and overrun is not set.
REQ-027 SHALL treat evt_ready as don't-care while evt_valid=0.
REQ-028 SHALL provide no combinational path from evt_ready to evt_valid, evt_chan or evt_level.

Reset
REQ-029 SHALL, while reset=1, clear prescaler, idx, rr_ptr, all histories, sig_out, pending and overrun, and force state IDLE.
REQ-030 SHALL, when reset asserts mid-SCAN, abort the scan with no partial update committed after that edge; the first tick after reset deasserts occurs PRESCALE cycles later.
REQ-031 SHALL keep evt_valid=0 and busy=0 during reset and in the first cycle after it.

Configuration
REQ-032 SHALL, with FILTER_SCHED_EVT_EN defined, implement pending, rr_ptr, the event handshake and overrun as above.
REQ-033 SHALL, with FILTER_SCHED_EVT_EN undefined, omit that logic: evt_valid, evt_chan, evt_level and overrun tied 0, evt_ready ignored, filtering unchanged.

Verification
REQ-034 SHALL cover ch0 held at 1 from reset, others 0, evt_ready=1: sig_out[0] rises after the 3rd ch0 scan, and one event with evt_chan=0, evt_level=1 is accepted.
REQ-035 SHALL cover ch1 toggling every 8 clocks (one value per tick): sig_out[1] stays 0 and no event is produced.
REQ-036 SHALL cover ch0 and ch2 rising in the same scan with evt_ready=0 for 20 cycles, then 1: events arrive in order chan 0 then chan 2, each held stable while stalled.
REQ-037 SHALL cover ch3 rising then falling with evt_ready=0 throughout: overrun=1, pending[3] stays set, and evt_level=0 when finally accepted.
REQ-038 SHALL cover reset pulsed for 1 cycle while busy=1 at idx=2: all outputs read 0, and the next busy rise occurs exactly PRESCALE cycles after reset deasserts.
REQ-039 SHALL cover a build without FILTER_SCHED_EVT_EN: the REQ-034 stimulus gives the same sig_out timing with evt_valid stuck at 0.
